// File: rtl/mem_bus_arbiter.sv
// Round-robin controller sharing one readM/writeM memory port among NUM_CH requesters.
// One transfer in flight at a time; a silent memory is aborted after TIMEOUT access cycles.
module mem_bus_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_CH    = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             ch_req,
  input  logic [NUM_CH-1:0]             ch_we,
  input  logic [NUM_CH*WORD_SIZE-1:0]   ch_addr,
  input  logic [NUM_CH*WORD_SIZE-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]             ch_gnt,
  output logic [NUM_CH-1:0]             ch_done,
  output logic [WORD_SIZE-1:0]          rdata,
  output logic                          err,
  output logic                          readM,
  output logic                          writeM,
  output logic [WORD_SIZE-1:0]          address,
  inout  wire  [WORD_SIZE-1:0]          data,
  input  logic                          inputReady,
  input  logic                          ackOutput
);

  localparam int ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ID_W-1:0]       r_id;
  logic                  r_we;
  logic [WORD_SIZE-1:0]  r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic                  r_readM;
  logic                  r_writeM;
  logic [NUM_CH-1:0]     r_gnt;
  logic [NUM_CH-1:0]     r_done;
  logic [WORD_SIZE-1:0]  r_rdata;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;
  logic [ID_W-1:0]       r_rr_ptr;

  logic                  w_found;
  logic [ID_W-1:0]       w_pick;
  logic [ID_W:0]         w_idx;
  logic [ID_W-1:0]       w_ptr_next;
  logic [NUM_CH-1:0]     w_pick_oh;
  logic [NUM_CH-1:0]     w_id_oh;
  logic                  w_resp;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_tmo;

  // Scan channels starting at the round-robin pointer, wrapping at NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_CH)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_CH);
      end
      if (!w_found && ch_req[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_pick == ID_W'(NUM_CH - 1)) ? '0 : w_pick + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign w_pick_oh[gi] = (w_pick == ID_W'(gi));
      assign w_id_oh[gi]   = (r_id == ID_W'(gi));
    end
  endgenerate

  // A real response on the timeout edge takes priority over the abort.
  assign w_resp    = r_we ? ackOutput : inputReady;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_found) w_state_next = S_ACCESS;
      S_ACCESS: if (w_resp || w_tmo) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_id     <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_readM  <= 1'b0;
      r_writeM <= 1'b0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id     <= w_pick;
            r_we     <= ch_we[w_pick];
            r_addr   <= ch_addr[w_pick*WORD_SIZE +: WORD_SIZE];
            r_wdata  <= ch_wdata[w_pick*WORD_SIZE +: WORD_SIZE];
            r_gnt    <= w_pick_oh;
            r_readM  <= !ch_we[w_pick];
            r_writeM <= ch_we[w_pick];
            r_cnt    <= '0;
            r_rr_ptr <= w_ptr_next;
          end
        end
        S_ACCESS: begin
          if (w_resp) begin
            if (!r_we) begin
              r_rdata <= data;
            end
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            r_err    <= 1'b0;
            r_done   <= w_id_oh;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_tmo) begin
              r_readM  <= 1'b0;
              r_writeM <= 1'b0;
              r_rdata  <= '1;
              r_err    <= 1'b1;
              r_done   <= w_id_oh;
            end
          end
        end
        S_RESP: begin
          r_err <= 1'b0;
        end
        default: begin
          r_readM  <= 1'b0;
          r_writeM <= 1'b0;
        end
      endcase
    end
  end

  assign ch_gnt  = r_gnt;
  assign ch_done = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;
  assign readM   = r_readM;
  assign writeM  = r_writeM;
  assign address = r_addr;
  assign data    = r_writeM ? r_wdata : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench: two requesters plus a latency-controlled memory, checked against a
// transaction-level model of round-robin order, memory contents, latency and timeout.
module tb_mem_bus_arbiter;

  localparam int W  = 16;
  localparam int NC = 2;
  localparam int TO = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [NC-1:0]   ch_req;
  logic [NC-1:0]   ch_we;
  logic [NC*W-1:0] ch_addr;
  logic [NC*W-1:0] ch_wdata;
  logic [NC-1:0]   ch_gnt;
  logic [NC-1:0]   ch_done;
  logic [W-1:0]    rdata;
  logic            err;
  logic            readM;
  logic            writeM;
  logic [W-1:0]    address;
  wire  [W-1:0]    data;
  logic            inputReady;
  logic            ackOutput;
  logic            tb_den;
  logic [W-1:0]    tb_dval;

  assign data = tb_den ? tb_dval : {W{1'bz}};

  mem_bus_arbiter #(.WORD_SIZE(W), .NUM_CH(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .ch_done(ch_done), .rdata(rdata), .err(err),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady), .ackOutput(ackOutput)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: pending requests, memory image, last rdata, arbitration pointer.
  bit           p_pend [NC];
  bit           p_we   [NC];
  logic [W-1:0] p_addr [NC];
  logic [W-1:0] p_wdata[NC];
  logic [W-1:0] mem     [0:255];
  logic [W-1:0] exp_mem [0:255];
  logic [W-1:0] exp_rdata;
  int           model_ptr;
  int           last_cyc;
  int           prev_acc;
  bit           have_prev;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post_req(input int c, input bit we, input logic [W-1:0] a, input logic [W-1:0] wd);
    p_pend[c]           = 1'b1;
    p_we[c]             = we;
    p_addr[c]           = a;
    p_wdata[c]          = wd;
    ch_req[c]           = 1'b1;
    ch_we[c]            = we;
    ch_addr[c*W +: W]   = a;
    ch_wdata[c*W +: W]  = wd;
  endtask

  // Strobes arriving outside ACCESS; the data-valid one only during the RESP edge.
  task automatic stray();
    if ($urandom_range(0, 2) == 0) begin
      ackOutput  = 1'b1;
      inputReady = 1'b1;
      tb_den     = 1'b1;
      tb_dval    = W'($urandom);
    end
  endtask

  // lat >= 0: memory answers after lat extra access cycles; lat < 0: memory stays silent.
  task automatic do_one(input int lat);
    int           exp_ch;
    int           waited;
    int           acc;
    bit           we;
    logic [W-1:0] a;
    logic [W-1:0] wd;
    bit           exp_err;

    exp_ch = -1;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (model_ptr + k) % NC;
      if (exp_ch < 0 && p_pend[c]) exp_ch = c;
    end
    if (exp_ch < 0) exp_ch = 0;

    tick();
    tb_den     = 1'b0;
    inputReady = 1'b0;
    check_val("done_clear", {29'd0, ch_done, err}, 32'd0);
    waited = 0;
    while (ch_gnt == '0 && waited < 6) begin
      tick();
      waited++;
    end
    ackOutput  = 1'b0;
    inputReady = 1'b0;
    check_val("gnt_seen", {31'd0, ch_gnt != '0}, 32'd1);
    if (ch_gnt == '0) return;

    we = p_we[exp_ch];
    a  = p_addr[exp_ch];
    wd = p_wdata[exp_ch];
    check_val("gnt_order", {30'd0, ch_gnt}, 32'd1 << exp_ch);
    if (have_prev) check_val("gnt_gap", cyc - last_cyc, prev_acc + 2);
    last_cyc  = cyc;
    model_ptr = (exp_ch + 1) % NC;
    check_val("strobes", {30'd0, readM, writeM}, {30'd0, !we, we});
    check_val("address", {16'd0, address}, {16'd0, a});
    if (we) check_val("wdata_bus", {16'd0, data}, {16'd0, wd});

    // Inputs of the granted channel no longer matter.
    ch_addr[exp_ch*W +: W]  = W'($urandom);
    ch_wdata[exp_ch*W +: W] = W'($urandom);
    ch_we[exp_ch]           = ~we;

    acc = 1;
    if (lat < 0) begin
      while ((readM || writeM) && acc < 40) begin
        tick();
        if (readM || writeM) acc++;
      end
      check_val("timeout_len", acc, TO);
      exp_rdata = '1;
      exp_err   = 1'b1;
    end else begin
      for (int i = 0; i < lat; i++) begin
        tick();
        acc++;
        check_val("hold", {14'd0, readM, writeM, address}, {14'd0, !we, we, a});
      end
      if (we) begin
        ackOutput = 1'b1;
        mem[a[7:0]] = data;
        exp_mem[a[7:0]] = wd;
      end else begin
        inputReady = 1'b1;
        tb_den     = 1'b1;
        tb_dval    = mem[a[7:0]];
        exp_rdata  = exp_mem[a[7:0]];
      end
      tick();
      ackOutput  = 1'b0;
      inputReady = 1'b0;
      tb_den     = 1'b0;
      exp_err    = 1'b0;
    end

    check_val("done", {30'd0, ch_done}, 32'd1 << exp_ch);
    check_val("err", {31'd0, err}, {31'd0, exp_err});
    check_val("rdata", {16'd0, rdata}, {16'd0, exp_rdata});
    check_val("strobes_off", {30'd0, readM, writeM}, 32'd0);
    $display("txn ch%0d %s addr %h wdata %h lat %0d -> rdata %h err %0d", exp_ch,
             we ? "WR" : "RD", a, wd, lat, rdata, err);
    p_pend[exp_ch] = 1'b0;
    ch_req[exp_ch] = 1'b0;
    prev_acc  = acc;
    have_prev = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    inputReady = 1'b0; ackOutput = 1'b0; tb_den = 1'b0; tb_dval = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = W'($urandom);
      exp_mem[i] = mem[i];
    end
    for (int c = 0; c < NC; c++) p_pend[c] = 1'b0;
    exp_rdata = '0; model_ptr = 0; last_cyc = 0; prev_acc = 0; have_prev = 1'b0;

    tick(); tick(); tick();
    check_val("rst_strobes", {30'd0, readM, writeM}, 32'd0);
    check_val("rst_addr", {16'd0, address}, 32'd0);
    check_val("rst_gnt_done", {28'd0, ch_gnt, ch_done}, 32'd0);
    check_val("rst_rdata_err", {15'd0, rdata, err}, 32'd0);
    reset = 1'b0;

    // Directed: slow read on ch0, then write on ch1.
    mem[8'h10] = 16'hA5A5;
    exp_mem[8'h10] = 16'hA5A5;
    post_req(0, 1'b0, 16'h0010, 16'h0000);
    do_one(1);
    post_req(1, 1'b1, 16'h0020, 16'h1234);
    do_one(1);

    // Both channels saturated with a zero-wait memory: strict alternation.
    post_req(0, 1'b0, 16'h0020, 16'h0000);
    post_req(1, 1'b0, 16'h0010, 16'h0000);
    for (int n = 0; n < 6; n++) begin
      int c;
      c = (model_ptr + NC) % NC;
      do_one(0);
      c = (c == 0) ? 0 : c;
      for (int k = 0; k < NC; k++) if (!p_pend[k]) post_req(k, 1'b0, W'(k * 16), 16'h0000);
    end
    do_one(0);
    do_one(0);

    // Silent memory and response exactly on the timeout edge.
    post_req(0, 1'b0, 16'h0003, 16'h0000);
    do_one(-1);
    stray();
    post_req(1, 1'b0, 16'h0010, 16'h0000);
    do_one(TO - 1);
    stray();

    for (int n = 0; n < 60; n++) begin
      int r;
      int lat;
      for (int c = 0; c < NC; c++) begin
        if (!p_pend[c] && $urandom_range(0, 99) < 65) begin
          post_req(c, 1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom));
        end
      end
      if (!p_pend[0] && !p_pend[1]) begin
        post_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 W'($urandom_range(0, 15)), W'($urandom));
      end
      r = int'($urandom_range(0, 9));
      if (r < 6)       lat = int'($urandom_range(0, 3));
      else if (r < 8)  lat = TO - 1;
      else if (r == 8) lat = -1;
      else             lat = 0;
      do_one(lat);
      stray();
    end

    // Reset in the middle of a ch0 write: no completion, pointer returns to ch0.
    tick();
    ackOutput = 1'b0; inputReady = 1'b0; tb_den = 1'b0;
    for (int c = 0; c < NC; c++) begin
      p_pend[c] = 1'b0;
      ch_req[c] = 1'b0;
    end
    tick();
    post_req(0, 1'b1, 16'h0005, 16'hBEEF);
    begin
      int waited;
      waited = 0;
      while (ch_gnt == '0 && waited < 6) begin
        tick();
        waited++;
      end
    end
    check_val("pre_rst_gnt", {30'd0, ch_gnt}, 32'd1);
    tick();
    check_val("pre_rst_write", {31'd0, writeM}, 32'd1);
    reset = 1'b1;
    tick();
    check_val("mid_rst_strobes", {30'd0, readM, writeM}, 32'd0);
    check_val("mid_rst_done", {30'd0, ch_done}, 32'd0);
    check_val("mid_rst_rdata", {16'd0, rdata}, 32'd0);
    reset = 1'b0;
    model_ptr = 0;
    exp_rdata = '0;
    have_prev = 1'b0;
    post_req(1, 1'b0, 16'h0010, 16'h0000);
    do_one(0);
    do_one(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised memory-port controller that lets `NUM_CH` requesters share the single `readM`/`writeM`/`address`/`data` memory port used by the CPU. It runs one transfer at a time, picks requesters round-robin, and sequences the `inputReady`/`ackOutput` handshake. A timeout aborts a transfer the memory never answers. It sits between the CPU's instruction-fetch and data-access paths, plus future DMA, and the memory model.

## Interface
Parameters:
- `WORD_SIZE`, 16: data and address width.
- `NUM_CH`, 2: number of requesters (≥1). Channel 0 is instruction fetch and channel 1 is data.
- `TIMEOUT`, 15: maximum cycles waiting for memory response. 0 disables the timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous active-high reset.
- `ch_req`  in  NUM_CH  level request per channel; held until that channel's `ch_done`.
- `ch_we`  in  NUM_CH  1 = write, 0 = read.
- `ch_addr`  in  NUM_CH*WORD_SIZE  flattened addresses; channel i at bits [i*WORD_SIZE +: WORD_SIZE].
- `ch_wdata`  in  NUM_CH*WORD_SIZE  flattened write data.
- `ch_gnt`  out  NUM_CH  one-hot, one-cycle pulse when a channel's request is latched.
- `ch_done`  out  NUM_CH  one-hot, one-cycle pulse when that channel's transfer ends.
- `rdata`  out  WORD_SIZE  read data; valid while `ch_done` is high.
- `err`  out  1  high with `ch_done` if the transfer timed out.
- `readM`  out  1  memory read strobe.
- `writeM`  out  1  memory write strobe.
- `address`  out  WORD_SIZE  memory address.
- `data`  inout  WORD_SIZE  driven with latched write data while `writeM`=1, otherwise high-Z.
- `inputReady`  in  1  memory read data valid; sampled on `clk`.
- `ackOutput`  in  1  memory write accepted; sampled on `clk`.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE**
  - If any `ch_req` is set, pick the first requesting channel at or after `rr_ptr`, wrapping modulo NUM_CH.
  - On that edge: latch its id, `ch_we`, address and wdata; pulse `ch_gnt[id]`; set `readM` = !we or `writeM` = we; set `address`; clear the timeout counter; go to ACCESS.
  - Set `rr_ptr` = (id+1) mod NUM_CH.
- **ACCESS**
  - `address`, the active strobe and driven data are held constant.
  - For a read, when `inputReady`=1 is sampled: capture `data` into `rdata`, drop `readM`, go to RESP.
  - For a write, when `ackOutput`=1 is sampled: drop `writeM` and release `data`, go to RESP.
  - Otherwise increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT: drop the strobes, set `rdata` = all ones, set `err`=1, go to RESP.
- **RESP**
  - Outputs registered: `ch_done[id]`=1 for exactly one cycle, `rdata`/`err` valid.
  - Next state is IDLE. Requests are not sampled in RESP, so the channel may drop `req` or present a new one.
  - `err` clears on leaving RESP. `rdata` holds until the next capture.
- Response strobes that arrive while in IDLE or RESP are ignored.
- `ch_req`/`ch_addr`/`ch_wdata` changes during ACCESS are ignored. The latched transfer completes and `ch_done` still pulses.
- `readM` and `writeM` are never high together.

## Timing
- Reset values: `readM`=0, `writeM`=0, `address`=0, `data`=Z, `ch_gnt`=0, `ch_done`=0, `rdata`=0, `err`=0, state=IDLE, `rr_ptr`=0, counter=0.
- Reset applied mid-transfer: strobes drop at that edge, `data` is released, and no `ch_done` is issued.
- Request seen at edge t gives strobe high after t. A response sampled at edge t+k gives strobe low and `ch_done` high after t+k, low after t+k+1.
- Minimum transfer is 3 cycles (IDLE, 1×ACCESS, RESP). Back-to-back grants are therefore ≥3 cycles apart.
- Response and timeout on the same edge: the response wins and `err`=0.
- Timeout asserts after exactly TIMEOUT ACCESS cycles with no response.
- With NUM_CH=1 the arbiter degenerates: `rr_ptr` is always 0.

## Test plan
- Single read, ch0, addr 0x0010, memory returns 0xA5A5 with `inputReady` 2 cycles after `readM` -> `readM` high 2 cycles with `address`=0x0010; `ch_done[0]` pulse; `rdata`=0xA5A5; `err`=0.
- Single write, ch1, addr 0x0020, data 0x1234 -> `writeM`=1 and `data`=0x1234 until `ackOutput`; then `data`=Z and `ch_done[1]` pulse; `readM` never high.
- Both channels requesting continuously, zero-wait memory -> grants alternate ch0, ch1, ch0, ch1, one every 3 cycles.
- Read with memory silent, TIMEOUT=15 -> `readM` drops after 15 ACCESS cycles; `ch_done` with `err`=1 and `rdata`=0xFFFF.
- Reset during a write's ACCESS -> next edge `writeM`=0 and `data`=Z; no `ch_done`; a following ch1 request is granted first (`rr_ptr`=0, ch0 idle).
- `inputReady` and timeout on the same edge, and a stray `ackOutput` in IDLE -> normal completion with `err`=0; the stray `ackOutput` has no effect.
